// File: rtl/bcd_pkg.sv
// Shared constants for the BCD digit adder and its binary add/correction stages.
package bcd_pkg;

  localparam int unsigned BCD_W    = 4;
  localparam logic [3:0]  BCD_MAX  = 4'd9;
  localparam logic [3:0]  BCD_CORR = 4'b0110;
  localparam logic [3:0]  BCD_ZERO = 4'b0000;

endpackage : bcd_pkg

// File: rtl/mux_4b.sv
// Combinational 2:1 operand mux feeding the adder's second operand.
module mux_4b
  import bcd_pkg::*;
#(
  parameter int unsigned W = BCD_W
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         sel,
  output logic [W-1:0] out
);

  always_comb begin
    out = sel ? in1 : in0;
  end

endmodule : mux_4b

// File: rtl/full_adder_4b_core.sv
// Registered 4-bit adder: y/co = a + (sel ? b1 : b0) + ci, one cycle latency.
module full_adder_4b_core
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH = BCD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] b1,
  input  logic             sel,
  input  logic             ci,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             co
);

  logic [WIDTH-1:0] m;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;

  mux_4b #(.W(WIDTH)) u_mux (
    .in0 (b0),
    .in1 (b1),
    .sel (sel),
    .out (m)
  );

  assign c[0] = ci;

  // Ripple chain; c[WIDTH] is the carry-out, so the full sum never loses a bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = a[i] ^ m[i] ^ c[i];
    assign c[i+1] = (a[i] & m[i]) | (c[i] & (a[i] ^ m[i]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      co        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y  <= s;
        co <= c[WIDTH];
      end
    end
  end

endmodule : full_adder_4b_core

// File: tb/tb_full_adder_4b_core.sv
// Directed and exhaustive checks for the registered 4-bit adder core.
module tb_full_adder_4b_core;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b0;
  logic [3:0] b1;
  logic       sel;
  logic       ci;
  logic       out_valid;
  logic [3:0] y;
  logic       co;

  int unsigned n_chk;
  int unsigned n_pass;

  full_adder_4b_core #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b0        (b0),
    .b1        (b1),
    .sel       (sel),
    .ci        (ci),
    .out_valid (out_valid),
    .y         (y),
    .co        (co)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b, expected %b", tag, got, exp);
  endtask

  // Drive at the negedge, let one posedge capture, sample at the following negedge.
  task automatic drive(input logic v, input logic [3:0] ta, input logic [3:0] tb0,
                       input logic [3:0] tb1, input logic ts, input logic tc);
    in_valid = v; a = ta; b0 = tb0; b1 = tb1; sel = ts; ci = tc;
    @(negedge clk);
  endtask

  // Compares {out_valid, co, y}
  function automatic logic [5:0] obs();
    return {out_valid, co, y};
  endfunction

  initial begin
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b0 = '0; b1 = '0; sel = 1'b0; ci = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", obs(), 6'b0_0_0000);
    rst_n = 1'b1;

    // Idle after release: nothing valid yet
    drive(1'b0, 4'd5, 4'd4, 4'd0, 1'b0, 1'b0);
    check("idle_after_release", obs(), 6'b0_0_0000);

    // Plain add 5+4
    drive(1'b1, 4'b0101, 4'b0100, 4'b0000, 1'b0, 1'b0);
    check("plain_add", obs(), 6'b1_0_1001);

    // Valid gating: y holds
    drive(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    check("valid_gate", obs(), 6'b0_0_1001);

    // Correction path 12+6=18
    drive(1'b1, 4'b1100, 4'b0000, 4'b0110, 1'b1, 1'b0);
    check("corr_12p6", obs(), 6'b1_1_0010);

    // Wrap cases, back to back
    drive(1'b1, 4'b1111, 4'b0001, 4'b0000, 1'b0, 1'b0);
    check("wrap_15p1", obs(), 6'b1_1_0000);
    drive(1'b1, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b1);
    check("wrap_15p15p1", obs(), 6'b1_1_1111);

    // Back-to-back stream in order
    drive(1'b1, 4'd3, 4'd2, 4'd9, 1'b0, 1'b0);
    check("b2b_0", obs(), 6'b1_0_0101);
    drive(1'b1, 4'd3, 4'd2, 4'd9, 1'b1, 1'b1);
    check("b2b_1", obs(), 6'b1_0_1101);
    drive(1'b1, 4'd8, 4'd0, 4'd6, 1'b1, 1'b1);
    check("b2b_2", obs(), 6'b1_0_1111);
    drive(1'b1, 4'd9, 4'd9, 4'd0, 1'b0, 1'b0);
    check("b2b_3", obs(), 6'b1_1_0010);

    // Async reset mid-cycle with out_valid=1, in_valid still high
    #2 rst_n = 1'b0;
    #1 check("async_reset", obs(), 6'b0_0_0000);
    @(posedge clk);
    #1 check("reset_held", obs(), 6'b0_0_0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 4'd7, 4'd7, 4'd0, 1'b0, 1'b0);
    check("first_after_reset", obs(), 6'b1_0_1110);

    // Exhaustive; the unselected input carries the complement to expose a swapped mux
    for (int unsigned s = 0; s < 2; s++) begin
      for (int unsigned c = 0; c < 2; c++) begin
        for (int unsigned i = 0; i < 16; i++) begin
          for (int unsigned j = 0; j < 16; j++) begin
            logic [3:0] va, vb;
            logic [4:0] sum;
            va  = 4'(i);
            vb  = 4'(j);
            sum = 5'(i + j + c);
            if (s == 0) drive(1'b1, va, vb, ~vb, 1'b0, 1'(c));
            else        drive(1'b1, va, ~vb, vb, 1'b1, 1'(c));
            check($sformatf("exh_s%0d_c%0d_%0d_%0d", s, c, i, j), obs(), {1'b1, sum});
          end
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_full_adder_4b_core
